// File: rtl/icache_refill_engine.sv
// icache_refill_engine: line-refill master for the instruction cache.
// Accepts one refill request, issues LINE_WORDS read beats on the memory port,
// gathers the in-order responses into a line buffer and returns the whole line.
// Optional feature macro: REFILL_CRITICAL_WORD_FIRST_EN.
//   - Defined: the requested word is fetched first and the remaining words
//     follow in wrap-around order.
//   - Undefined: words are fetched in ascending order from the line base.
module icache_refill_engine #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 64,
  parameter int LINE_WORDS     = 4
) (
  input  logic                             CLK,
  input  logic                             INITN,
  input  logic                             refill_req_i,
  output logic                             refill_gnt_o,
  input  logic [ADDR_WIDTH-1:0]            refill_addr_i,
  output logic                             refill_rvalid_o,
  input  logic                             refill_rready_i,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] refill_rdata_o,
  output logic                             busy_o,
  output logic                             protocol_err_o,
  output logic                             mem_cen_o,
  output logic [MEM_ADDR_WIDTH-1:0]        mem_a_o,
  input  logic                             mem_gnt_i,
  output logic                             mem_wen_o,
  output logic [DATA_WIDTH-1:0]            mem_d_o,
  output logic [DATA_WIDTH/8-1:0]          mem_be_o,
  input  logic [DATA_WIDTH-1:0]            mem_q_i,
  input  logic                             mem_rval_i
);

  localparam int OFFS      = $clog2(DATA_WIDTH / 8);
  localparam int LWB       = $clog2(LINE_WORDS);
  localparam int CW        = LWB + 1;
  localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [LWB-1:0]            start_q, start_d;
  logic [CW-1:0]             issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]             rx_cnt_q, rx_cnt_d;
  logic [LINE_BITS-1:0]      line_q, line_d;
  logic                      perr_q, perr_d;

  logic [MEM_ADDR_WIDTH-1:0] word_addr;
  logic [LWB-1:0]            issue_ofs;
  logic [LWB-1:0]            rx_ofs;
  logic                      rval_ok;
  logic                      sig_unused;

  assign word_addr = refill_addr_i[OFFS +: MEM_ADDR_WIDTH];

  // Responses are only legal while beats are outstanding; anything else is stray.
  assign rval_ok = mem_rval_i && (rx_cnt_q < issue_cnt_q);

  // Beat index to line-slot offset; critical-word-first rotates by the requested word.
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  assign issue_ofs = start_q + issue_cnt_q[LWB-1:0];
  assign rx_ofs    = start_q + rx_cnt_q[LWB-1:0];
`else
  assign issue_ofs = issue_cnt_q[LWB-1:0];
  assign rx_ofs    = rx_cnt_q[LWB-1:0];
`endif

  // Byte-offset bits, high address bits and (in the in-order build) the start word are not needed.
  assign sig_unused = ^{refill_addr_i, start_q};

  // Next-state logic: FSM transitions, beat counters, line buffer fill and error flag.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    start_d     = start_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    line_d      = line_q;
    perr_d      = 1'b0;

    if (rval_ok) begin
      line_d[rx_ofs*DATA_WIDTH +: DATA_WIDTH] = mem_q_i;
      rx_cnt_d = rx_cnt_q + CW'(1);
    end else if (mem_rval_i) begin
      perr_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (refill_req_i) begin
          base_d      = {word_addr[MEM_ADDR_WIDTH-1:LWB], {LWB{1'b0}}};
          start_d     = word_addr[LWB-1:0];
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
          if (issue_cnt_d == FULL_CNT) begin
            state_d = (rx_cnt_d == FULL_CNT) ? DONE : DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rx_cnt_d == FULL_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (refill_rready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; a reset aborts any refill.
  always_ff @(posedge CLK) begin
    if (!INITN) begin
      state_q     <= IDLE;
      base_q      <= '0;
      start_q     <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      line_q      <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      start_q     <= start_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      line_q      <= line_d;
      perr_q      <= perr_d;
    end
  end

  assign refill_gnt_o    = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign refill_rvalid_o = (state_q == DONE);
  assign refill_rdata_o  = line_q;
  assign protocol_err_o  = perr_q;

  assign mem_cen_o = (state_q != ISSUE);
  assign mem_a_o   = base_q + MEM_ADDR_WIDTH'(issue_ofs);
  assign mem_wen_o = 1'b1;
  assign mem_d_o   = '0;
  assign mem_be_o  = '1;

endmodule
